// File: rtl/legv8_pkg.sv
// -----------------------------------------------------------------------------
// legv8_pkg
//   Shared constants and types for the LEGv8 instruction encode/load path.
//   Holds the 11-bit R/D-format opcodes, the CB/B-format prefixes, the
//   host-side operation enumeration and the loader FSM state type.
// -----------------------------------------------------------------------------
package legv8_pkg;

   // Host-side operation selector carried on IN_OP
   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_ORR  = 3'd3,
      OP_LDUR = 3'd4,
      OP_STUR = 3'd5,
      OP_CBZ  = 3'd6,
      OP_B    = 3'd7
   } op_e;

   // Loader session states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } load_state_e;

   // R-format and D-format 11-bit opcodes
   localparam logic [10:0] OPC_ADD  = 11'b10001011000;
   localparam logic [10:0] OPC_SUB  = 11'b11001011000;
   localparam logic [10:0] OPC_AND  = 11'b10001010000;
   localparam logic [10:0] OPC_ORR  = 11'b10101010000;
   localparam logic [10:0] OPC_LDUR = 11'b11111000010;
   localparam logic [10:0] OPC_STUR = 11'b11111000000;

   // CB-format and B-format prefixes
   localparam logic [7:0]  PFX_CBZ  = 8'b10110100;
   localparam logic [5:0]  PFX_B    = 6'b000101;

   // Byte stride between consecutive instruction words
   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/instr_encode_loader_if.sv
// -----------------------------------------------------------------------------
// instr_encode_loader_if
//   Bundles the instruction-field handshake (host -> loader) and the
//   instruction-memory write port (loader -> memory).
//   master : host/memory side (drives fields, IN_VALID, IMEM_READY)
//   slave  : loader side (drives IN_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA)
// -----------------------------------------------------------------------------
interface instr_encode_loader_if;
   logic        IN_VALID;
   logic        IN_READY;
   logic [2:0]  IN_OP;
   logic [4:0]  IN_RD;
   logic [4:0]  IN_RN;
   logic [4:0]  IN_RM;
   logic [25:0] IN_IMM;
   logic        IMEM_WE;
   logic        IMEM_READY;
   logic [63:0] IMEM_ADDR;
   logic [31:0] IMEM_WDATA;

   modport master (
      output IN_VALID, IN_OP, IN_RD, IN_RN, IN_RM, IN_IMM, IMEM_READY,
      input  IN_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA
   );

   modport slave (
      input  IN_VALID, IN_OP, IN_RD, IN_RN, IN_RM, IN_IMM, IMEM_READY,
      output IN_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA
   );
endinterface

// File: rtl/legv8_instr_encoder.sv
// -----------------------------------------------------------------------------
// legv8_instr_encoder
//   Purely combinational LEGv8 encoder with immediate range checking.
//   Ports:
//     op        in  3   operation (legv8_pkg::op_e encoding)
//     rd        in  5   Rd, or Rt for LDUR/STUR/CBZ
//     rn        in  5   Rn
//     rm        in  5   Rm
//     imm       in  26  signed immediate (byte offset for D-format,
//                       word offset for CBZ/B)
//     word      out 32  encoded instruction
//     range_err out 1   immediate does not fit the target field
// -----------------------------------------------------------------------------
module legv8_instr_encoder
   import legv8_pkg::*;
(
   input  logic [2:0]         op,
   input  logic [4:0]         rd,
   input  logic [4:0]         rn,
   input  logic [4:0]         rm,
   input  logic signed [25:0] imm,
   output logic [31:0]        word,
   output logic               range_err
);

   // A value fits a narrower signed field when every bit above the field's
   // sign bit is a copy of that sign bit.
   function automatic logic fits_imm9(input logic signed [25:0] v);
      return (v[25:8] == {18{v[8]}});
   endfunction

   function automatic logic fits_imm19(input logic signed [25:0] v);
      return (v[25:18] == {8{v[18]}});
   endfunction

   always_comb begin
      word      = '0;
      range_err = 1'b0;
      case (op_e'(op))
         OP_ADD:  word = {OPC_ADD, rm, 6'b000000, rn, rd};
         OP_SUB:  word = {OPC_SUB, rm, 6'b000000, rn, rd};
         OP_AND:  word = {OPC_AND, rm, 6'b000000, rn, rd};
         OP_ORR:  word = {OPC_ORR, rm, 6'b000000, rn, rd};
         OP_LDUR: begin
            word      = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
            range_err = ~fits_imm9(imm);
         end
         OP_STUR: begin
            word      = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
            range_err = ~fits_imm9(imm);
         end
         OP_CBZ: begin
            word      = {PFX_CBZ, imm[18:0], rd};
            range_err = ~fits_imm19(imm);
         end
         OP_B:    word = {PFX_B, imm[25:0]};
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// -----------------------------------------------------------------------------
// instr_encode_loader
//   Accepts symbolic LEGv8 instruction fields, encodes them and writes the
//   words sequentially into instruction memory starting at BASE_ADDR.
//   Ports:
//     CLOCK       in   1   rising-edge clock
//     RESET_N     in   1   asynchronous active-low reset
//     START       in   1   pulse: open a load session (from IDLE or DONE)
//     FINISH      in   1   pulse: close the session (in LOAD only)
//     bus         slave   field handshake + instruction-memory write port
//     WORD_COUNT  out  7   words committed to memory in this session
//     LOAD_DONE   out  1   session closed and all writes drained
//     ERR         out  1   sticky: an immediate was out of range
//   Parameters:
//     BASE_ADDR   byte address of the first word
//     DEPTH       maximum words per session
// -----------------------------------------------------------------------------
module instr_encode_loader
   import legv8_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR = 64'd0,
   parameter int unsigned DEPTH     = 64
)
(
   input  logic                   CLOCK,
   input  logic                   RESET_N,
   input  logic                   START,
   input  logic                   FINISH,
   instr_encode_loader_if.slave   bus,
   output logic [6:0]             WORD_COUNT,
   output logic                   LOAD_DONE,
   output logic                   ERR
);

   load_state_e state, state_nxt;

   logic [31:0] enc_word;
   logic        enc_err;

   logic        vld_p1;      // write pending toward memory
   logic [31:0] wdata_p1;
   logic [63:0] addr;
   logic [6:0]  count;
   logic        err;

   logic        in_ready;
   logic        open_session;
   logic        xfer;
   logic        commit;
   logic        accept_ok;
   logic [31:0] inflight;
   logic [31:0] inflight_nxt;

   legv8_instr_encoder u_encoder (
      .op        (bus.IN_OP),
      .rd        (bus.IN_RD),
      .rn        (bus.IN_RN),
      .rm        (bus.IN_RM),
      .imm       (bus.IN_IMM),
      .word      (enc_word),
      .range_err (enc_err)
   );

   assign commit    = vld_p1 & bus.IMEM_READY;
   assign xfer      = bus.IN_VALID & in_ready;
   assign accept_ok = xfer & ~enc_err;

   // Committed plus pending words. A commit only moves a word from pending
   // to committed, so next cycle's total grows only by a legal acceptance.
   assign inflight     = {25'd0, count} + {31'd0, vld_p1};
   assign inflight_nxt = inflight + {31'd0, accept_ok};

   // ---- FSM: state register ----
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // ---- FSM: next-state logic ----
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (START) state_nxt = ST_LOAD;
         ST_LOAD:  if (FINISH || (inflight_nxt >= DEPTH)) state_nxt = ST_DRAIN;
         ST_DRAIN: if (!vld_p1) state_nxt = ST_DONE;
         ST_DONE:  if (START) state_nxt = ST_LOAD;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      in_ready     = (state == ST_LOAD) && (!vld_p1 || bus.IMEM_READY) &&
                     (inflight < DEPTH);
      open_session = START && ((state == ST_IDLE) || (state == ST_DONE));
      LOAD_DONE    = (state == ST_DONE);
   end

   // ---- stage p1: encoded word register, address and word counters ----
   // A rejected (out-of-range) transfer is consumed without queuing a write,
   // so the address and count only ever advance on a real memory commit.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         vld_p1   <= 1'b0;
         wdata_p1 <= '0;
         addr     <= BASE_ADDR;
         count    <= '0;
         err      <= 1'b0;
      end else if (open_session) begin
         vld_p1   <= 1'b0;
         addr     <= BASE_ADDR;
         count    <= '0;
         err      <= 1'b0;
      end else begin
         if (commit) begin
            addr  <= addr + 64'(WORD_BYTES);
            count <= count + 7'd1;
         end
         if (xfer) begin
            vld_p1 <= ~enc_err;
            if (enc_err) err      <= 1'b1;
            else         wdata_p1 <= enc_word;
         end else if (commit) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.IN_READY   = in_ready;
   assign bus.IMEM_WE    = vld_p1;
   assign bus.IMEM_ADDR  = addr;
   assign bus.IMEM_WDATA = wdata_p1;
   assign WORD_COUNT     = count;
   assign ERR            = err;

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Writer-side counterpart to the instruction decoder: accepts symbolic LEGv8 instruction fields and encodes them into 32-bit words.
- Writes the words sequentially into instruction memory, so test programs for the CPU are produced by hardware instead of hand-coded hex.
- Sits between a testbench or host source and the instruction-memory write port.
- Supports ADD, SUB, AND, ORR, LDUR, STUR, CBZ and B, with range checking and memory back-pressure.

Parameters:
- BASE_ADDR, 64'd0: byte address of the first encoded word.
- DEPTH, 64: maximum number of words per load session.

Ports:
- CLOCK  input  1  Single clock. All state changes on its rising edge.
- RESET_N  input  1  Asynchronous, active-low reset.
- START  input  1  Single-cycle pulse that opens a load session.
- FINISH  input  1  Single-cycle pulse that closes the session.
- IN_VALID  input  1  Instruction fields are valid.
- IN_READY  output  1  Block accepts fields this cycle.
- IN_OP  input  3  Operation: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 B.
- IN_RD  input  5  Rd, or Rt for LDUR/STUR/CBZ.
- IN_RN  input  5  Rn.
- IN_RM  input  5  Rm.
- IN_IMM  input  26  Signed immediate: word offset for B/CBZ, byte offset for LDUR/STUR.
- IMEM_WE  output  1  Write request to instruction memory.
- IMEM_READY  input  1  Memory accepts the write this cycle.
- IMEM_ADDR  output  64  Write byte address.
- IMEM_WDATA  output  32  Encoded instruction word.
- WORD_COUNT  output  7  Words committed in this session.
- LOAD_DONE  output  1  Session closed.
- ERR  output  1  Sticky flag: an immediate was out of range.

Behaviour:
- Reset (asynchronous, while RESET_N=0):
  - State is IDLE.
  - IN_READY=0, IMEM_WE=0, IMEM_ADDR=BASE_ADDR, IMEM_WDATA=0, WORD_COUNT=0, LOAD_DONE=0, ERR=0.
  - Reset mid-session discards any pending write with no further IMEM_WE.
- FSM states IDLE, LOAD, DRAIN, DONE:
  - IDLE -> LOAD on START. Clears WORD_COUNT and ERR; sets the address to BASE_ADDR.
  - LOAD -> DRAIN on FINISH, or when the accepted plus pending word count reaches DEPTH.
  - DRAIN -> DONE once no write is pending.
  - DONE holds LOAD_DONE=1. START in DONE behaves as it does in IDLE.
  - START is ignored in LOAD and DRAIN.
  - FINISH outside LOAD is ignored.
- Handshake rules:
  - IN_READY = (state==LOAD) && (no write pending, or IMEM_READY this cycle) && (WORD_COUNT + pending < DEPTH).
  - A transfer occurs when IN_VALID && IN_READY.
  - If FINISH and a transfer fall in the same cycle, the transfer is accepted, then DRAIN is entered.
- Write latency:
  - The encoded word appears on IMEM_WDATA with IMEM_WE=1 one cycle after acceptance.
  - It holds stable until IMEM_READY=1 is seen.
  - On each IMEM_WE && IMEM_READY: IMEM_ADDR += 4 and WORD_COUNT += 1 on the next edge.
  - Back-to-back throughput is one word per cycle while IMEM_READY stays high.
- Encodings:
  - ADD/SUB/AND/ORR: {opc11, Rm, 6'b0, Rn, Rd}. opc11 is 10001011000, 11001011000, 10001010000 and 10101010000 respectively.
  - LDUR/STUR: {11111000010 or 11111000000, imm9, 2'b00, Rn, Rt}.
  - CBZ: {10110100, imm19, Rt}.
  - B: {000101, imm26}.
- Range rules:
  - imm9 must satisfy -256 <= IN_IMM <= 255.
  - imm19 must satisfy -2^18 <= IN_IMM <= 2^18-1. The upper IN_IMM bits must be a sign-extension of the field.
  - A violating transfer is still accepted, but nothing is written and WORD_COUNT is not incremented. ERR is set and stays set until the next START.
  - Fields unused by an operation are ignored.
- Capacity:
  - When WORD_COUNT reaches DEPTH, IN_READY stays 0.
  - IMEM_ADDR never exceeds BASE_ADDR + 4*DEPTH; there is no wrap-around.

Decomposition:
- Shared package legv8_pkg holds:
  - The 11-bit opcode constants for ADD, SUB, AND, ORR, LDUR and STUR.
  - The CBZ 8-bit prefix and the B 6-bit prefix.
  - The IN_OP enumeration.
- Separate the purely combinational encoder and range check into the sub-module legv8_instr_encoder: inputs are the op and fields; outputs are word[31:0] and range_err.
- The FSM, output register, address counter and word counter live in the top.

Test Plan:
- Reset, START, ADD with Rd=3, Rn=1, Rm=2, IMEM_READY=1 -> one cycle later IMEM_WE=1, IMEM_ADDR=0, IMEM_WDATA=0x8B020023; then WORD_COUNT=1.
- LDUR with Rt=2, Rn=1, IMM=8, then B with IMM=-1, then CBZ with Rt=5, IMM=2 -> words 0xF8408022, 0x17FFFFFF, 0xB4000045 at addresses 0, 4, 8.
- LDUR with IMM=300 -> ERR=1, no IMEM_WE, WORD_COUNT unchanged; the next legal word is written at the unchanged address.
- IMEM_READY held 0 for 3 cycles during a stream -> IN_READY=0, IMEM_WDATA/IMEM_ADDR stable; the stream resumes with no word lost or duplicated.
- DEPTH=4 with 6 words offered -> exactly 4 written, IN_READY stays low, state reaches DONE, LOAD_DONE=1, WORD_COUNT=4.
- RESET_N pulled low while a write is pending -> outputs return to reset values immediately; a new START writes from BASE_ADDR with WORD_COUNT=0.
